// File: rtl/iot_input_buffer.sv
// Peripheral input buffer for the M101 bus: synchronizes the device strobe, latches characters,
// keeps the ready/overrun flags, and answers IOP1/IOP2/IOP4 pulses with skip, AC-clear and bus read.
module iot_input_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dev_data,
    input  logic        dev_strobe,
    input  logic        io_select,
    input  logic        iop1,
    input  logic        iop2,
    input  logic        iop4,
    input  logic        int_en,
    output logic [11:0] bus_data,
    output logic        bus_enable,
    output logic        skip,
    output logic        ac_clear,
    output logic        flag,
    output logic        overrun,
    output logic        int_req
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync2_d;
    logic [1:0] r_settle;
    logic       r_armed;
    logic       r_iop1_d;
    logic       r_iop2_d;
    logic [7:0] r_buf;
    logic       r_flag;
    logic       r_ovr;
    logic       r_pend_valid;
    logic [7:0] r_pend_data;
    logic       r_pend_ovr;
    logic       r_bus_en;
    logic       r_skip;
    logic       r_ac_clr;

    logic       w_load_evt;
    logic       w_iop1_evt;
    logic       w_iop2_evt;
    logic       w_defer;
    logic       w_apply;
    logic       w_load_now;
    logic       w_flag_kept;
    logic       w_ovr_kept;
    logic       w_lost;
    logic [7:0] w_buf_next;
    logic       w_flag_next;
    logic       w_ovr_next;

    // The detector is armed only after the synchronized strobe has been seen low once the
    // synchronizer has refilled after reset, so a strobe held across reset never loads.
    assign w_load_evt  = r_armed & r_sync2 & ~r_sync2_d;
    assign w_iop1_evt  = iop1 & ~r_iop1_d & io_select;
    assign w_iop2_evt  = iop2 & ~r_iop2_d & io_select;

    assign w_defer     = w_load_evt & r_bus_en;
    assign w_apply     = r_pend_valid & ~r_bus_en;
    assign w_load_now  = w_load_evt & ~r_bus_en;

    assign w_flag_kept = r_flag & ~w_iop2_evt;
    assign w_ovr_kept  = r_ovr & ~w_iop2_evt;

    // A character is lost when a new one lands on an unread (and not just cleared) buffer,
    // or when the pending slot had already been overwritten while the bus was busy.
    assign w_lost = (w_apply & (w_flag_kept | r_pend_ovr))
                  | (w_load_now & (w_apply | w_flag_kept));

    always_comb begin
        w_buf_next = r_buf;
        if (w_load_now) begin
            w_buf_next = dev_data;
        end else if (w_apply) begin
            w_buf_next = r_pend_data;
        end
    end

    assign w_flag_next = w_load_now | w_apply | w_flag_kept;
    assign w_ovr_next  = w_ovr_kept | w_lost;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync2_d    <= 1'b0;
            r_settle     <= 2'd0;
            r_armed      <= 1'b0;
            r_iop1_d     <= 1'b0;
            r_iop2_d     <= 1'b0;
            r_buf        <= 8'h00;
            r_flag       <= 1'b0;
            r_ovr        <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 8'h00;
            r_pend_ovr   <= 1'b0;
            r_bus_en     <= 1'b0;
            r_skip       <= 1'b0;
            r_ac_clr     <= 1'b0;
        end else begin
            r_sync1   <= dev_strobe;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end
            if ((r_settle == 2'd2) && !r_sync2) begin
                r_armed <= 1'b1;
            end

            r_iop1_d <= iop1;
            r_iop2_d <= iop2;

            r_buf  <= w_buf_next;
            r_flag <= w_flag_next;
            r_ovr  <= w_ovr_next;

            // The pending slot holds at most one character while a bus read is in progress.
            if (w_defer) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= dev_data;
                r_pend_ovr   <= r_pend_ovr | r_pend_valid;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
                r_pend_ovr   <= 1'b0;
            end

            r_bus_en <= iop4 & io_select;
            r_skip   <= w_iop1_evt & r_flag;
            r_ac_clr <= w_iop2_evt;
        end
    end

    assign bus_data   = r_bus_en ? {4'h0, r_buf} : 12'h000;
    assign bus_enable = r_bus_en;
    assign skip       = r_skip;
    assign ac_clear   = r_ac_clr;
    assign flag       = r_flag;
    assign overrun    = r_ovr;
    assign int_req    = r_flag & int_en;

endmodule

// File: tb/tb_iot_input_buffer.sv
// Bench for iot_input_buffer: directed scenarios plus a randomized run against a
// character-level reference model of the buffer, flags and IOP responses.
module tb_iot_input_buffer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  dev_data;
    logic        dev_strobe;
    logic        io_select;
    logic        iop1;
    logic        iop2;
    logic        iop4;
    logic        int_en;
    logic [11:0] bus_data;
    logic        bus_enable;
    logic        skip;
    logic        ac_clear;
    logic        flag;
    logic        overrun;
    logic        int_req;

    int checks   = 0;
    int failures = 0;

    iot_input_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dev_data   (dev_data),
        .dev_strobe (dev_strobe),
        .io_select  (io_select),
        .iop1       (iop1),
        .iop2       (iop2),
        .iop4       (iop4),
        .int_en     (int_en),
        .bus_data   (bus_data),
        .bus_enable (bus_enable),
        .skip       (skip),
        .ac_clear   (ac_clear),
        .flag       (flag),
        .overrun    (overrun),
        .int_req    (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: strobe samples since reset, character slots, flags.
    logic [7:0] m_buf      = 8'h00;
    logic       m_flag     = 1'b0;
    logic       m_ovr      = 1'b0;
    logic       m_ben      = 1'b0;
    logic       m_skip     = 1'b0;
    logic       m_acl      = 1'b0;
    logic       m_p1       = 1'b0;
    logic       m_p2       = 1'b0;
    logic [7:0] m_pend[$];
    logic       m_pend_lost = 1'b0;
    logic       m_hist[$];
    int         m_k        = 0;

    task automatic model_edge();
        logic load, e1, e2, ben_old, cur_flag;
        int   n;
        if (!rst_n) begin
            m_buf = 8'h00; m_flag = 0; m_ovr = 0; m_ben = 0; m_skip = 0; m_acl = 0;
            m_p1 = 0; m_p2 = 0; m_pend.delete(); m_pend_lost = 0; m_hist.delete(); m_k = 0;
            return;
        end
        m_hist.push_back(dev_strobe);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_k++;
        n = m_hist.size();
        // A character loads two edges after the first high sample, provided the sample
        // before it was a post-reset low.
        load = (m_k >= 4) && m_hist[n-3] && !m_hist[n-4];
        e1 = iop1 && !m_p1 && io_select;
        e2 = iop2 && !m_p2 && io_select;
        m_p1 = iop1;
        m_p2 = iop2;
        ben_old = m_ben;
        m_skip = e1 && m_flag;
        m_acl  = e2;
        m_ben  = iop4 && io_select;
        cur_flag = m_flag && !e2;
        if (e2) m_ovr = 0;
        if (load && ben_old) begin
            if (m_pend.size() > 0) m_pend_lost = 1;
            m_pend.delete();
            m_pend.push_back(dev_data);
        end else begin
            if (!ben_old && m_pend.size() > 0) begin
                if (cur_flag || m_pend_lost) m_ovr = 1;
                m_buf = m_pend.pop_front();
                m_pend_lost = 0;
                cur_flag = 1;
            end
            if (load) begin
                if (cur_flag) m_ovr = 1;
                m_buf = dev_data;
                cur_flag = 1;
            end
        end
        m_flag = cur_flag;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] d, input int width);
        dev_data = d;
        dev_strobe = 1'b1;
        repeat (width) step();
        dev_strobe = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        int_en = 1'b1;
        repeat (2) step();
        checks++; if (bus_data !== 12'h000) begin failures++; $display("FAIL reset_bus_data got=%h exp=000", bus_data); end
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL reset_bus_enable got=%b exp=0", bus_enable); end
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", flag); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (skip !== 1'b0 || ac_clear !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", skip, ac_clear); end
        checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_load();
        dev_data = 8'hC1;
        dev_strobe = 1'b1;
        step();
        step();
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL load_flag_early got=%b exp=0", flag); end
        step();
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL load_flag_third_edge got=%b exp=1", flag); end
        checks++; if (int_req !== 1'b1) begin failures++; $display("FAIL load_int_req got=%b exp=1", int_req); end
        repeat (2) step();
        dev_strobe = 1'b0;
        repeat (6) step();
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL load_flag_stays got=%b exp=1", flag); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL load_single_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_skip_read();
        io_select = 1'b1;
        iop1 = 1'b1;
        step();
        checks++; if (skip !== 1'b1) begin failures++; $display("FAIL skip_pulse got=%b exp=1", skip); end
        step();
        checks++; if (skip !== 1'b0) begin failures++; $display("FAIL skip_held_no_retrigger got=%b exp=0", skip); end
        iop1 = 1'b0;
        step();
        iop4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_enable !== 1'b1) begin failures++; $display("FAIL read_bus_enable cyc=%0d got=%b exp=1", i, bus_enable); end
            checks++; if (bus_data !== 12'h0C1) begin failures++; $display("FAIL read_bus_data cyc=%0d got=%h exp=0c1", i, bus_data); end
        end
        iop4 = 1'b0;
        step();
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL read_bus_enable_off got=%b exp=0", bus_enable); end
        checks++; if (bus_data !== 12'h000) begin failures++; $display("FAIL read_bus_data_off got=%h exp=000", bus_data); end
    endtask

    task automatic test_clear();
        io_select = 1'b0;
        iop2 = 1'b1;
        step();
        checks++; if (ac_clear !== 1'b0) begin failures++; $display("FAIL clear_unselected_ac got=%b exp=0", ac_clear); end
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL clear_unselected_flag got=%b exp=1", flag); end
        iop2 = 1'b0;
        step();
        io_select = 1'b1;
        iop2 = 1'b1;
        step();
        checks++; if (ac_clear !== 1'b1) begin failures++; $display("FAIL clear_ac_pulse got=%b exp=1", ac_clear); end
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL clear_flag got=%b exp=0", flag); end
        iop2 = 1'b0;
        step();
        checks++; if (ac_clear !== 1'b0) begin failures++; $display("FAIL clear_ac_one_cycle got=%b exp=0", ac_clear); end
    endtask

    task automatic test_overrun_collision();
        send_char(8'h41, 2);
        send_char(8'h42, 3);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        io_select = 1'b1;
        iop4 = 1'b1;
        step();
        checks++; if (bus_data !== 12'h042) begin failures++; $display("FAIL overrun_buffer got=%h exp=042", bus_data); end
        iop4 = 1'b0;
        step();
        dev_data = 8'h43;
        dev_strobe = 1'b1;
        step();
        step();
        iop2 = 1'b1;
        step();
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL collision_flag got=%b exp=1", flag); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL collision_overrun got=%b exp=0", overrun); end
        checks++; if (ac_clear !== 1'b1) begin failures++; $display("FAIL collision_ac_clear got=%b exp=1", ac_clear); end
        iop2 = 1'b0;
        dev_strobe = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_deferral();
        io_select = 1'b1;
        iop2 = 1'b1; step();
        iop2 = 1'b0; step();
        send_char(8'h41, 2);
        iop4 = 1'b1;
        step();
        dev_data = 8'h55;
        dev_strobe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus_data !== 12'h041) begin failures++; $display("FAIL defer_bus_hold cyc=%0d got=%h exp=041", i, bus_data); end
        end
        dev_strobe = 1'b0;
        step();
        checks++; if (bus_data !== 12'h041) begin failures++; $display("FAIL defer_bus_hold_end got=%h exp=041", bus_data); end
        iop4 = 1'b0;
        step();
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL defer_bus_fall got=%b exp=0", bus_enable); end
        iop4 = 1'b1;
        step();
        checks++; if (bus_data !== 12'h055) begin failures++; $display("FAIL defer_applied_data got=%h exp=055", bus_data); end
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL defer_applied_flag got=%b exp=1", flag); end
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL defer_overrun got=%b exp=%b", overrun, m_ovr); end
        iop4 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        io_select = 1'b1;
        iop2 = 1'b1; step();
        iop2 = 1'b0; step();
        iop4 = 1'b1;
        step();
        dev_data = 8'h66;
        dev_strobe = 1'b1;
        repeat (2) step();
        dev_strobe = 1'b0;
        repeat (4) step();
        dev_data = 8'h77;
        dev_strobe = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        checks++; if (bus_data !== 12'h000 || bus_enable !== 1'b0) begin failures++; $display("FAIL rstmid_bus got=%h/%b exp=000/0", bus_data, bus_enable); end
        checks++; if (flag !== 1'b0 || overrun !== 1'b0 || int_req !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b%b exp=000", flag, overrun, int_req); end
        checks++; if (skip !== 1'b0 || ac_clear !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got=%b%b exp=00", skip, ac_clear); end
        rst_n = 1'b1;
        iop4 = 1'b0;
        repeat (8) step();
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL rstmid_held_strobe_flag got=%b exp=0", flag); end
        dev_strobe = 1'b0;
        repeat (3) step();
        dev_data = 8'h78;
        dev_strobe = 1'b1;
        repeat (3) step();
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL rstmid_new_strobe_flag got=%b exp=1", flag); end
        dev_strobe = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_random();
        int hi = 0;
        int lo = 4;
        logic [11:0] exp_bus;
        for (int i = 0; i < 800; i++) begin
            if (dev_strobe) begin
                hi--;
                if (hi == 0) begin
                    dev_strobe = 1'b0;
                    lo = $urandom_range(4, 8);
                end
            end else if (lo > 0) begin
                lo--;
            end else begin
                dev_data = 8'($urandom_range(0, 255));
                dev_strobe = 1'b1;
                hi = $urandom_range(1, 4);
            end
            io_select = ($urandom_range(0, 3) != 0);
            iop1 = ($urandom_range(0, 2) == 0);
            iop2 = ($urandom_range(0, 4) == 0);
            iop4 = ($urandom_range(0, 3) == 0);
            int_en = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 199) != 0);
            step();
            exp_bus = m_ben ? {4'h0, m_buf} : 12'h000;
            checks++; if (bus_data !== exp_bus) begin failures++; $display("FAIL rand_bus_data i=%0d got=%h exp=%h", i, bus_data, exp_bus); end
            checks++; if (bus_enable !== m_ben) begin failures++; $display("FAIL rand_bus_enable i=%0d got=%b exp=%b", i, bus_enable, m_ben); end
            checks++; if (flag !== m_flag) begin failures++; $display("FAIL rand_flag i=%0d got=%b exp=%b", i, flag, m_flag); end
            checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rand_overrun i=%0d got=%b exp=%b", i, overrun, m_ovr); end
            checks++; if (skip !== m_skip) begin failures++; $display("FAIL rand_skip i=%0d got=%b exp=%b", i, skip, m_skip); end
            checks++; if (ac_clear !== m_acl) begin failures++; $display("FAIL rand_ac_clear i=%0d got=%b exp=%b", i, ac_clear, m_acl); end
            checks++; if (int_req !== (m_flag & int_en)) begin failures++; $display("FAIL rand_int_req i=%0d got=%b exp=%b", i, int_req, m_flag & int_en); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dev_data = 8'h00;
        dev_strobe = 1'b0;
        io_select = 1'b0;
        iop1 = 1'b0;
        iop2 = 1'b0;
        iop4 = 1'b0;
        int_en = 1'b0;
        test_reset();
        test_load();
        test_skip_read();
        test_clear();
        test_overrun_collision();
        test_deferral();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iot_input_buffer.md
IOT_INPUT_BUFFER -- requirements
Module: iot_input_buffer

Purpose: 8-bit peripheral input buffer with flag/IOT logic; feeds the M101 bus data interface. bus_data drives the M101 data inputs and bus_enable drives M101 C1.

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of clk.
REQ-002 SHALL provide ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
dev_data  in  8  device character, stable while dev_strobe high and 4 cycles after
dev_strobe  in  1  asynchronous "character ready" level from device
io_select  in  1  device code matched, synchronous to clk
iop1  in  1  IOT pulse 1 (skip-on-flag), synchronous level
iop2  in  1  IOT pulse 2 (clear flag / clear AC), synchronous level
iop4  in  1  IOT pulse 4 (read buffer onto bus), synchronous level
int_en  in  1  interrupt enable
bus_data  out  12  to M101 data inputs; bits 11:8 always 0
bus_enable  out  1  to M101 C1
skip  out  1  I/O skip request, one-cycle pulse
ac_clear  out  1  AC clear request, one-cycle pulse
flag  out  1  character-ready flag
overrun  out  1  character lost
int_req  out  1  interrupt request

Function
REQ-003 SHALL pass dev_strobe through a 2-flop synchronizer, then rising-edge detect; a strobe SHALL register as one load event regardless of its width.
REQ-004 Load event SHALL capture dev_data into the 8-bit buffer and set flag on the 3rd rising edge after dev_strobe is first sampled high.
REQ-005 Load event while flag=1 SHALL overwrite the buffer and set overrun.
REQ-006 Each iop input SHALL be rising-edge detected with one register; an IOP event counts only if io_select=1 at the same edge.
REQ-007 IOP1 event: skip SHALL pulse high for exactly one cycle (the cycle after the sampling edge) iff flag=1 at that edge.
REQ-008 IOP2 event: ac_clear SHALL pulse one cycle; flag and overrun SHALL clear on the same edge.
REQ-009 Simultaneous load and IOP2 event on one edge: load wins; flag=1, overrun=0, buffer=new data, ac_clear still pulses.
REQ-010 bus_enable SHALL be registered iop4 & io_select: high one cycle after both sampled high, low one cycle after either drops.
REQ-011 bus_data[7:0] SHALL equal the buffer while bus_enable=1, and 0 otherwise.
REQ-012 Load event arriving while bus_enable=1 SHALL be held in a 1-deep pending register (data + event) and applied on the edge after bus_enable falls; flag/overrun update then. Second load while pending SHALL replace the pending data and set overrun on apply.
REQ-013 Held IOP levels SHALL NOT retrigger; a new event requires the iop to go low then high again.
REQ-014 int_req SHALL be combinational flag & int_en.
REQ-015 IOP1, IOP2 and IOP4 events in the same cycle SHALL each act independently; skip uses flag before the IOP2 clear.

Reset
REQ-016 rst_n=0 at a clock edge SHALL clear buffer, pending register, synchronizer, edge-detect registers, flag, overrun, skip, ac_clear and bus_enable; bus_data=0.
REQ-017 Reset mid-operation (strobe in synchronizer, pending load, bus_enable high) SHALL discard all in-flight events; a dev_strobe still high after reset release SHALL NOT cause a load until it goes low and high again.

Verification
REQ-018 Scenario load: dev_data=0xC1, dev_strobe high 5 cycles -> flag=1 on 3rd edge, stays 1; one load only; overrun=0.
REQ-019 Scenario skip/read: flag=1, io_select=1, iop1 pulse -> skip one cycle; iop4 high 3 cycles -> bus_enable high 3 cycles, bus_data=0x0C1, then 0x000.
REQ-020 Scenario clear: iop2 with io_select=1 -> ac_clear one cycle, flag=0; with io_select=0 -> no effect.
REQ-021 Scenario overrun/collision: two strobes (0x41, 0x42) without clear -> buffer=0x42, overrun=1; strobe completing on same edge as IOP2 -> flag=1, overrun=0.
REQ-022 Scenario deferral: strobe 0x55 during iop4 read of 0x41 -> bus_data stays 0x041 until bus_enable falls; next edge buffer=0x55, flag=1.
REQ-023 Scenario reset: rst_n low with pending load and bus_enable=1 -> all outputs 0 next edge; held dev_strobe does not load after release.
